// File: rtl/cm_fifo_push_arbiter.sv
// Packet-level push arbiter for the CM FIFO write port: grants one whole packet at a time to
// one of two producers, marks each packet's first byte with SOP and pads stalled packets.
module cm_fifo_push_arbiter #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       FFE_CLK_gclk,
  input  logic       rst,
  input  logic [3:0] CM_FIFO_PushFlags,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] len0,
  input  logic [6:0] len1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic       wvalid0,
  input  logic       wvalid1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       CM_FIFO_Push,
  output logic [8:0] CM_FIFO_PushData,
  output logic       busy,
  input  logic       err_clr,
  output logic       pad_err
);

  typedef enum logic [1:0] {StIdle, StXfer, StPad, StSettle} state_e;

  localparam logic [7:0] TimeoutW = 8'(TIMEOUT);

  state_e     r_state;
  logic       r_last;     // 1: requester 1 was granted most recently
  logic       r_sel;      // requester owning the current packet
  logic [6:0] r_len;
  logic [6:0] r_cnt;
  logic [7:0] r_wd;
  logic       r_settle;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_push;
  logic [8:0] r_data;
  logic       r_pad_err;

  logic [31:0] w_room;
  logic        w_elig0;
  logic        w_elig1;
  logic        w_any;
  logic        w_win1;
  logic        w_wvalid;
  logic [7:0]  w_wdata;
  logic [6:0]  w_cnt_inc;
  logic [7:0]  w_wd_inc;
  logic        w_sop;
  logic        w_pad_set;

  // Lower bound on free FIFO words implied by the push flags.
  always_comb begin
    w_room = '0;
    case (CM_FIFO_PushFlags)
      4'h1:    w_room = 32'(DEPTH);
      4'h2:    w_room = 32'(DEPTH / 2);
      4'h3:    w_room = 32'(DEPTH / 4);
      4'h4:    w_room = 32'd64;
      4'hA:    w_room = 32'd32;
      4'hB:    w_room = 32'd16;
      4'hC:    w_room = 32'd8;
      4'hD:    w_room = 32'd4;
      4'hE:    w_room = 32'd2;
      4'hF:    w_room = 32'd1;
      default: w_room = '0;
    endcase
  end

  always_comb begin
    w_elig0   = req0 && (len0 != 7'd0) && (32'(len0) <= w_room);
    w_elig1   = req1 && (len1 != 7'd0) && (32'(len1) <= w_room);
    w_any     = w_elig0 || w_elig1;
    // On a tie the requester not granted last wins.
    w_win1    = w_elig1 && (!w_elig0 || !r_last);
    w_wvalid  = r_sel ? wvalid1 : wvalid0;
    w_wdata   = r_sel ? wdata1 : wdata0;
    w_cnt_inc = r_cnt + 7'd1;
    w_wd_inc  = (r_wd == 8'hFF) ? r_wd : r_wd + 8'd1;
    w_sop     = (r_cnt == 7'd0);
    w_pad_set = (r_state == StXfer) && !w_wvalid && (w_wd_inc == TimeoutW);
  end

  always_ff @(posedge FFE_CLK_gclk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_last    <= 1'b1;
      r_sel     <= 1'b0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_wd      <= '0;
      r_settle  <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_push    <= 1'b0;
      r_data    <= '0;
      r_pad_err <= 1'b0;
    end else begin
      r_push    <= 1'b0;
      r_pad_err <= w_pad_set || (r_pad_err && !err_clr);
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_sel   <= w_win1;
            r_last  <= w_win1;
            r_gnt0  <= !w_win1;
            r_gnt1  <= w_win1;
            r_len   <= w_win1 ? len1 : len0;
            r_cnt   <= '0;
            r_wd    <= '0;
            r_state <= StXfer;
          end
        end
        StXfer: begin
          if (w_wvalid) begin
            r_push <= 1'b1;
            r_data <= {w_sop, w_wdata};
            r_cnt  <= w_cnt_inc;
            r_wd   <= '0;
            if (w_cnt_inc == r_len) begin
              r_gnt0   <= 1'b0;
              r_gnt1   <= 1'b0;
              r_settle <= 1'b0;
              r_state  <= StSettle;
            end
          end else begin
            r_wd <= w_wd_inc;
            if (w_wd_inc == TimeoutW) begin
              r_gnt0  <= 1'b0;
              r_gnt1  <= 1'b0;
              r_state <= StPad;
            end
          end
        end
        StPad: begin
          r_push <= 1'b1;
          r_data <= {w_sop, 8'h00};
          r_cnt  <= w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            r_settle <= 1'b0;
            r_state  <= StSettle;
          end
        end
        StSettle: begin
          // Two cycles let the FIFO push flags catch up with the last write.
          if (r_settle) begin
            r_state <= StIdle;
          end else begin
            r_settle <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign gnt0             = r_gnt0;
  assign gnt1             = r_gnt1;
  assign CM_FIFO_Push     = r_push;
  assign CM_FIFO_PushData = r_data;
  assign busy             = (r_state != StIdle);
  assign pad_err          = r_pad_err;

endmodule

// File: tb/tb_cm_fifo_push_arbiter.sv
// Directed bench for cm_fifo_push_arbiter: arbitration/room-decode vector table plus
// hand-written sequences for packet data, round-robin, watchdog padding and reset.
module tb_cm_fifo_push_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] flags = '0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [6:0] len0 = '0, len1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       wvalid0 = 1'b0, wvalid1 = 1'b0;
  logic       err_clr = 1'b0;
  logic       gnt0, gnt1, push, busy, pad_err;
  logic [8:0] pdata;

  always #5 clk = ~clk;

  cm_fifo_push_arbiter #(
    .DEPTH  (512),
    .TIMEOUT(16)
  ) dut (
    .FFE_CLK_gclk     (clk),
    .rst              (rst),
    .CM_FIFO_PushFlags(flags),
    .req0             (req0),
    .req1             (req1),
    .len0             (len0),
    .len1             (len1),
    .wdata0           (wdata0),
    .wdata1           (wdata1),
    .wvalid0          (wvalid0),
    .wvalid1          (wvalid1),
    .gnt0             (gnt0),
    .gnt1             (gnt1),
    .CM_FIFO_Push     (push),
    .CM_FIFO_PushData (pdata),
    .busy             (busy),
    .err_clr          (err_clr),
    .pad_err          (pad_err)
  );

  typedef struct {
    logic [3:0] flags;
    logic       r0;
    logic [6:0] l0;
    logic       r1;
    logic [6:0] l1;
    int         exp;  // 0 none, 1 gnt0, 2 gnt1
  } vec_t;

  vec_t       tbl[19];
  int         n_chk = 0;
  int         n_pass = 0;
  logic [8:0] pq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed bytes from the granted requester until its grant drops, capturing pushes.
  task automatic run_xfer(input int who, input logic [7:0] base);
    int n = 0;
    pq.delete();
    while (((who == 0) ? gnt0 : gnt1) && n < 300) begin
      if (who == 0) begin
        wvalid0 = 1'b1;
        wdata0  = base + 8'(n);
      end else begin
        wvalid1 = 1'b1;
        wdata1  = base + 8'(n);
      end
      tick();
      n++;
      if (push) pq.push_back(pdata);
    end
    wvalid0 = 1'b0;
    wvalid1 = 1'b0;
    check("xfer_gnt_drop", 32'(n < 300), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("return_to_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int         n;
    int         who;
    int         cnt;
    logic       bad;
    logic [8:0] f;
    logic [8:0] exp_a[4];
    logic [1:0] eg;

    // Room-decode and arbitration vectors; r_last history carried across entries.
    tbl[0]  = '{4'h1, 1'b1, 7'd2,   1'b1, 7'd2,  2};
    tbl[1]  = '{4'h0, 1'b1, 7'd1,   1'b0, 7'd0,  0};
    tbl[2]  = '{4'h2, 1'b1, 7'd100, 1'b0, 7'd0,  1};
    tbl[3]  = '{4'h3, 1'b1, 7'd127, 1'b1, 7'd0,  1};
    tbl[4]  = '{4'h4, 1'b1, 7'd65,  1'b0, 7'd0,  0};
    tbl[5]  = '{4'h4, 1'b1, 7'd64,  1'b0, 7'd0,  1};
    tbl[6]  = '{4'hA, 1'b1, 7'd33,  1'b1, 7'd32, 2};
    tbl[7]  = '{4'hB, 1'b1, 7'd16,  1'b1, 7'd17, 1};
    tbl[8]  = '{4'hC, 1'b1, 7'd10,  1'b1, 7'd8,  2};
    tbl[9]  = '{4'hA, 1'b1, 7'd10,  1'b1, 7'd8,  1};
    tbl[10] = '{4'hD, 1'b0, 7'd0,   1'b1, 7'd4,  2};
    tbl[11] = '{4'hE, 1'b1, 7'd3,   1'b1, 7'd2,  2};
    tbl[12] = '{4'hF, 1'b1, 7'd1,   1'b0, 7'd0,  1};
    tbl[13] = '{4'hF, 1'b0, 7'd0,   1'b1, 7'd2,  0};
    tbl[14] = '{4'h5, 1'b1, 7'd1,   1'b0, 7'd0,  0};
    tbl[15] = '{4'h9, 1'b0, 7'd0,   1'b1, 7'd1,  0};
    tbl[16] = '{4'h1, 1'b1, 7'd0,   1'b0, 7'd0,  0};
    tbl[17] = '{4'h1, 1'b1, 7'd0,   1'b1, 7'd1,  2};
    tbl[18] = '{4'hF, 1'b1, 7'd1,   1'b1, 7'd1,  1};
    exp_a   = '{9'h111, 9'h012, 9'h013, 9'h014};

    // Reset values
    #2 rst = 1'b1;
    #1;
    check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("rst_push", 32'(push), 32'd0);
    check("rst_data", 32'(pdata), 32'd0);
    check("rst_busy_err", {30'd0, busy, pad_err}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Round-robin with both requests held: 0,1,0,1
    flags = 4'h1;
    req0 = 1'b1; len0 = 7'd2;
    req1 = 1'b1; len1 = 7'd2;
    for (int p = 0; p < 4; p++) begin
      n = 0;
      while (!gnt0 && !gnt1 && n < 10) begin
        tick();
        n++;
      end
      check($sformatf("alt%0d_gnt", p), {30'd0, gnt1, gnt0},
            (p % 2 == 0) ? 32'd1 : 32'd2);
      who = gnt1 ? 1 : 0;
      run_xfer(who, 8'h40 + 8'(p * 4));
      f = (pq.size() > 0) ? pq[0] : 9'h1FF;
      check($sformatf("alt%0d_len", p), 32'(pq.size()), 32'd2);
      check($sformatf("alt%0d_first", p), 32'(f), 32'({1'b1, 8'h40 + 8'(p * 4)}));
    end
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle();

    // Four-byte packet, exact data and timing; requester 1 wvalid must be ignored
    flags = 4'h1;
    req0 = 1'b1; len0 = 7'd4;
    wvalid1 = 1'b1; wdata1 = 8'hEE;
    tick();
    check("a_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    check("a_busy", 32'(busy), 32'd1);
    req0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wvalid0 = 1'b1;
      wdata0  = 8'h11 + 8'(k);
      tick();
      check($sformatf("a_push%0d", k), {22'd0, push, pdata}, {22'd0, 1'b1, exp_a[k]});
      check($sformatf("a_gnt%0d", k), 32'(gnt0), (k == 3) ? 32'd0 : 32'd1);
    end
    wvalid0 = 1'b0;
    wvalid1 = 1'b0;
    tick();
    check("a_settle", {30'd0, push, busy}, 32'd1);
    tick();
    check("a_idle", 32'(busy), 32'd0);

    // Vector table
    for (int i = 0; i < 19; i++) begin
      flags = tbl[i].flags;
      req0 = tbl[i].r0; len0 = tbl[i].l0;
      req1 = tbl[i].r1; len1 = tbl[i].l1;
      tick();
      eg = (tbl[i].exp == 1) ? 2'b01 : (tbl[i].exp == 2) ? 2'b10 : 2'b00;
      check($sformatf("vec%0d_gnt", i), {30'd0, gnt1, gnt0}, {30'd0, eg});
      if (tbl[i].exp != 0) begin
        req0 = 1'b0;
        req1 = 1'b0;
        who = tbl[i].exp - 1;
        run_xfer(who, 8'(i * 16));
        f = (pq.size() > 0) ? pq[0] : 9'h0;
        check($sformatf("vec%0d_len", i), 32'(pq.size()),
              32'((who == 1) ? tbl[i].l1 : tbl[i].l0));
        check($sformatf("vec%0d_sop", i), 32'(f[8]), 32'd1);
        wait_idle();
      end else begin
        tick();
        tick();
        check($sformatf("vec%0d_none", i), {29'd0, busy, gnt1, gnt0}, 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end

    // Watchdog: 2 of 5 bytes, then stall for TIMEOUT=16 cycles
    flags = 4'h1;
    req1 = 1'b1; len1 = 7'd5;
    n = 0;
    while (!gnt1 && n < 10) begin
      tick();
      n++;
    end
    check("wd_gnt", {30'd0, gnt1, gnt0}, 32'd2);
    req1 = 1'b0;
    wvalid1 = 1'b1; wdata1 = 8'hA1;
    tick();
    check("wd_b0", {22'd0, push, pdata}, {22'd0, 1'b1, 9'h1A1});
    wdata1 = 8'hA2;
    tick();
    check("wd_b1", {22'd0, push, pdata}, {22'd0, 1'b1, 9'h0A2});
    wvalid1 = 1'b0;
    repeat (15) tick();
    check("wd_still_gnt", {30'd0, gnt1, pad_err}, 32'd2);
    tick();
    check("wd_drop", {29'd0, gnt1, pad_err, busy}, 32'd3);
    cnt = 0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (push) begin
        cnt++;
        if (pdata != 9'h000) bad = 1'b1;
      end
    end
    check("wd_pad_count", 32'(cnt), 32'd3);
    check("wd_pad_data", 32'(bad), 32'd0);
    wait_idle();
    check("wd_err_sticky", 32'(pad_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("wd_err_clr", 32'(pad_err), 32'd0);

    // Reset in the middle of a 6-byte packet
    req0 = 1'b1; len0 = 7'd6;
    tick();
    check("rm_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    req0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wvalid0 = 1'b1;
      wdata0  = 8'h30 + 8'(k);
      tick();
    end
    wvalid0 = 1'b0;
    check("rm_pre", {30'd0, push, busy}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rm_async", {18'd0, gnt0, gnt1, push, pdata, busy, pad_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    req0 = 1'b1; len0 = 7'd2;
    tick();
    check("rm_regnt", {30'd0, gnt1, gnt0}, 32'd1);
    req0 = 1'b0;
    run_xfer(0, 8'h77);
    f = (pq.size() > 0) ? pq[0] : 9'h0;
    check("rm_sop", 32'(f), 32'h177);
    check("rm_len", 32'(pq.size()), 32'd2);
    wait_idle();

    // Zero-length request held: never granted
    req0 = 1'b1; len0 = 7'd0;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (gnt0 || gnt1 || busy) bad = 1'b1;
    end
    check("len0_never", 32'(bad), 32'd0);
    req0 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
